// File: rtl/pad_scan_pkg.sv
// Shared constants, key-code type and index helper for the 4x4 pad scanner.
package pad_scan_pkg;

   localparam int unsigned ROWS   = 4;
   localparam int unsigned COLS   = 4;
   localparam int unsigned NKEYS  = ROWS * COLS;
   localparam int unsigned ROW_W  = 2;
   localparam int unsigned COL_W  = 2;
   localparam int unsigned CODE_W = ROW_W + COL_W;

   typedef logic [CODE_W-1:0] key_code_t;

   // Flat key index: row * COLS + col.
   function automatic key_code_t key_idx(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/pad_debounce_cell.sv
// Per-key debounce: counts consecutive differing samples and holds the debounced level.
module pad_debounce_cell #(
   parameter int unsigned DEB_CNT = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sample_i,
   input  logic raw_i,
   input  logic commit_i,
   output logic eligible_c_o,
   output logic held_o
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned INC_W = CNT_W + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             held_q, held_d;
   logic [INC_W-1:0] inc_c;
   logic             diff_c;
   logic             reach_c;

   assign diff_c       = raw_i ^ held_q;
   assign inc_c        = {1'b0, cnt_q} + INC_W'(1);
   assign reach_c      = inc_c >= INC_W'(DEB_CNT);
   // Eligibility counts the increment made at this very sample.
   assign eligible_c_o = sample_i && diff_c && reach_c;
   assign held_o       = held_q;

   // Next count / level: commit toggles and clears, otherwise saturating count on samples.
   always_comb begin
      cnt_d  = cnt_q;
      held_d = held_q;
      if (commit_i) begin
         cnt_d  = '0;
         held_d = ~held_q;
      end else if (sample_i) begin
         if (!diff_c) begin
            cnt_d = '0;
         end else if (reach_c) begin
            cnt_d = CNT_W'(DEB_CNT);
         end else begin
            cnt_d = inc_c[CNT_W-1:0];
         end
      end
   end

   // Count and debounced level registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         held_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         held_q <= held_d;
      end
   end

endmodule

// File: rtl/pad_scan_ctrl.sv
// Row-scan controller for the 4x4 pad: dwell timing, row select, debounce and event output.
module pad_scan_ctrl
   import pad_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEB_CNT  = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Scan_En,
   output logic [ROW_W-1:0] Row,
   input  logic [COLS-1:0]  Col,
   output logic             KeyValid,
   input  logic             KeyReady,
   output key_code_t        KeyCode,
   output logic             KeyPress,
   output logic [NKEYS-1:0] Held
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             valid_q, valid_d;
   key_code_t        code_q, code_d;
   logic             press_q, press_d;

   logic             wrap_c;
   logic             samp_c;
   logic [NKEYS-1:0] elig_c;
   logic [NKEYS-1:0] held_c;
   logic [NKEYS-1:0] commit_c;
   logic [COLS-1:0]  row_elig_c;
   logic             win_c;
   logic [COL_W-1:0] win_col_c;
   key_code_t        win_key_c;
   logic             slot_free_c;
   logic             do_commit_c;

   // Sample on the last dwell cycle so the decoder and matrix have settled.
   assign wrap_c      = div_q == DIV_W'(SCAN_DIV - 1);
   assign samp_c      = Scan_En && wrap_c;
   assign row_elig_c  = elig_c[key_idx(row_q, '0) +: COLS];
   assign win_key_c   = key_idx(row_q, win_col_c);
   assign slot_free_c = !valid_q || KeyReady;
   assign do_commit_c = win_c && slot_free_c;

   // Dwell counter and row select; both frozen while scanning is disabled.
   always_comb begin
      div_d = div_q;
      row_d = row_q;
      if (Scan_En) begin
         if (wrap_c) begin
            div_d = '0;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   // Lowest eligible column of the current row wins.
   always_comb begin
      win_c     = 1'b0;
      win_col_c = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (row_elig_c[c]) begin
            win_c     = 1'b1;
            win_col_c = COL_W'(c);
         end
      end
   end

   // One-hot commit strobe to the winning key's cell.
   always_comb begin
      commit_c = '0;
      if (do_commit_c) begin
         commit_c[win_key_c] = 1'b1;
      end
   end

   // Output slot: drop on handshake, reload on commit (commit wins).
   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      press_d = press_q;
      if (valid_q && KeyReady) begin
         valid_d = 1'b0;
      end
      if (do_commit_c) begin
         valid_d = 1'b1;
         code_d  = win_key_c;
         press_d = ~held_c[win_key_c];
      end
   end

   // State registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         code_q  <= '0;
         press_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         press_q <= press_d;
      end
   end

   for (genvar k = 0; k < NKEYS; k++) begin : g_cell
      pad_debounce_cell #(
         .DEB_CNT(DEB_CNT)
      ) u_cell (
         .clk_i       (CLK),
         .rst_i       (RST),
         .sample_i    (samp_c && (row_q == ROW_W'(k / COLS))),
         .raw_i       (Col[k % COLS]),
         .commit_i    (commit_c[k]),
         .eligible_c_o(elig_c[k]),
         .held_o      (held_c[k])
      );
   end

   assign Row      = row_q;
   assign KeyValid = valid_q;
   assign KeyCode  = code_q;
   assign KeyPress = press_q;
   assign Held     = held_c;

endmodule
